// File: rtl/i2c_sensor_poller.sv
// ---------------------------------------------------------------------------
// i2c_sensor_poller
//
// Purpose: periodically reads a 16-bit register from an I2C sensor through a
// byte-oriented I2C master. Each poll first writes the register pointer
// (REG_PTR) to DEV_ADDR, then reads two bytes back (MSB first). A good read
// updates sample_out; a failed write or short read pulses error_out and bumps
// a saturating error counter.
//
// Optional feature: define POLLER_TIMEOUT_EN to add a watchdog that forces a
// poll into the error path after TIMEOUT_CYCLES cycles in any one non-idle
// state. Without it a poll waits on ready_in indefinitely.
//
// Ports:
//   clk_in            sole clock, rising edge
//   n_rst             asynchronous active-low reset
//   poll_en_in        enables the periodic poll timer
//   enable_out        command strobe to the I2C master
//   rd_wr_out         0 = write, 1 = read
//   continuous_out    keep the bus for a follow-on transfer (repeated start)
//   address_out[6:0]  7-bit slave address (always DEV_ADDR)
//   data_bytes_out[5:0] byte count of the current transfer
//   wr_data_out[7:0]  byte to write (register pointer)
//   ready_in          master idle / accepting a command
//   wr_valid_in       master reports a write byte ACKed
//   rd_valid_in       master presents a read byte on rd_data_in
//   rd_data_in[7:0]   read byte from the master
//   sample_out[15:0]  last good sample
//   sample_valid_out  one-cycle pulse when sample_out updates
//   error_out         one-cycle pulse on a failed poll
//   err_cnt_out[7:0]  saturating failure count
//   busy_out          high whenever a poll is in progress
// ---------------------------------------------------------------------------
module i2c_sensor_poller #(
    parameter int       CLK_IN_FREQ_MHZ = 10,
    parameter int       POLL_PERIOD_US  = 1000,
    parameter logic [6:0] DEV_ADDR      = 7'h40,
    parameter logic [7:0] REG_PTR       = 8'h02,
    parameter int       TIMEOUT_CYCLES  = 100000
) (
    input  logic       clk_in,
    input  logic       n_rst,
    input  logic       poll_en_in,
    output logic       enable_out,
    output logic       rd_wr_out,
    output logic       continuous_out,
    output logic [6:0] address_out,
    output logic [5:0] data_bytes_out,
    output logic [7:0] wr_data_out,
    input  logic       ready_in,
    input  logic       wr_valid_in,
    input  logic       rd_valid_in,
    input  logic [7:0] rd_data_in,
    output logic [15:0] sample_out,
    output logic       sample_valid_out,
    output logic       error_out,
    output logic [7:0] err_cnt_out,
    output logic       busy_out
);

    localparam logic [31:0] PER_TC = 32'(CLK_IN_FREQ_MHZ * POLL_PERIOD_US - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        DONE,
        ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_enable;
    logic        w_cont;
    logic        w_wd_expired;

    logic [31:0] r_per_cnt;
    logic        r_pending;
    logic        r_wr_ok;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_rx_hi;
    logic [7:0]  r_rx_lo;
    logic        r_rd_wr;
    logic [5:0]  r_nbytes;
    logic [7:0]  r_wr_data;
    logic [15:0] r_sample;
    logic [7:0]  r_err_cnt;

    // A write ACK arriving in the same cycle ready_in returns still counts.
    logic        w_wr_ok;
    assign w_wr_ok = r_wr_ok | wr_valid_in;

    // -----------------------------------------------------------------------
    // Next-state and command strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_enable    = 1'b0;
        w_cont      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending && ready_in) w_state_nxt = WR_REQ;
            end
            WR_REQ: begin
                w_cont = 1'b1;
                // enable drops combinationally once the master goes busy
                if (!ready_in) w_state_nxt = WR_WAIT;
                else           w_enable    = 1'b1;
            end
            WR_WAIT: begin
                if (ready_in) w_state_nxt = w_wr_ok ? RD_REQ : ERR;
            end
            RD_REQ: begin
                w_cont = 1'b1;
                if (!ready_in) w_state_nxt = RD_WAIT;
                else           w_enable    = 1'b1;
            end
            RD_WAIT: begin
                if (ready_in) w_state_nxt = (r_byte_cnt == 2'd2) ? DONE : ERR;
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_wd_expired) begin
            w_state_nxt = ERR;
            w_enable    = 1'b0;
        end
    end

`ifdef POLLER_TIMEOUT_EN
    localparam logic [31:0] WD_TC = 32'(TIMEOUT_CYCLES - 1);

    // Watchdog: counts cycles in the current non-idle state, restarting on
    // every state change so each handshake phase gets the full budget.
    logic [31:0] r_wd_cnt;

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == IDLE || w_state_nxt != r_state) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end

    assign w_wd_expired = (r_wd_cnt == WD_TC) &&
                          (r_state != IDLE) && (r_state != DONE) && (r_state != ERR);
`else
    assign w_wd_expired = 1'b0;

    // TIMEOUT_CYCLES stays in the parameter list so both builds share one
    // instantiation; this empty guard is its only reference here.
    if (TIMEOUT_CYCLES < 0) begin : g_wd_param_unused
    end
`endif

    // -----------------------------------------------------------------------
    // State, poll timer, capture and status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_per_cnt  <= '0;
            r_pending  <= 1'b0;
            r_wr_ok    <= 1'b0;
            r_byte_cnt <= '0;
            r_rx_hi    <= '0;
            r_rx_lo    <= '0;
            r_rd_wr    <= 1'b0;
            r_nbytes   <= '0;
            r_wr_data  <= '0;
            r_sample   <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (!poll_en_in || r_per_cnt == PER_TC) r_per_cnt <= '0;
            else                                    r_per_cnt <= r_per_cnt + 32'd1;

            // A tick wins over the start-of-poll clear, so a tick landing on
            // the launch cycle still yields one follow-on poll.
            if (poll_en_in && r_per_cnt == PER_TC)
                r_pending <= 1'b1;
            else if (!poll_en_in || (r_state == IDLE && w_state_nxt == WR_REQ))
                r_pending <= 1'b0;

            if (r_state == IDLE)                     r_wr_ok <= 1'b0;
            else if (r_state == WR_WAIT && wr_valid_in) r_wr_ok <= 1'b1;

            if (r_state == IDLE) begin
                r_byte_cnt <= '0;
            end else if (r_state == RD_WAIT && rd_valid_in && r_byte_cnt != 2'd2) begin
                if (r_byte_cnt == 2'd0) r_rx_hi <= rd_data_in;
                else                    r_rx_lo <= rd_data_in;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            // Command fields are loaded on entry and held through the wait
            // state, so they stay stable while the master is busy.
            if (w_state_nxt == WR_REQ) begin
                r_rd_wr   <= 1'b0;
                r_nbytes  <= 6'd1;
                r_wr_data <= REG_PTR;
            end else if (w_state_nxt == RD_REQ) begin
                r_rd_wr   <= 1'b1;
                r_nbytes  <= 6'd2;
            end

            // Loaded on entry to DONE so sample_out is already new while
            // sample_valid_out is high.
            if (w_state_nxt == DONE) r_sample <= {r_rx_hi, r_rx_lo};

            if (w_state_nxt == ERR && r_state != ERR && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign enable_out       = w_enable;
    assign continuous_out   = w_cont;
    assign rd_wr_out        = r_rd_wr;
    assign address_out      = DEV_ADDR;
    assign data_bytes_out   = r_nbytes;
    assign wr_data_out      = r_wr_data;
    assign sample_out       = r_sample;
    assign sample_valid_out = (r_state == DONE);
    assign error_out        = (r_state == ERR);
    assign err_cnt_out      = r_err_cnt;
    assign busy_out         = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_sensor_poller.sv
module tb_i2c_sensor_poller;

    localparam int PERIOD = 40;

    logic        clk_in = 1'b0;
    logic        n_rst;
    logic        poll_en_in;
    logic        enable_out, rd_wr_out, continuous_out;
    logic [6:0]  address_out;
    logic [5:0]  data_bytes_out;
    logic [7:0]  wr_data_out;
    logic        ready_in, wr_valid_in, rd_valid_in;
    logic [7:0]  rd_data_in;
    logic [15:0] sample_out;
    logic        sample_valid_out, error_out, busy_out;
    logic [7:0]  err_cnt_out;

    i2c_sensor_poller #(
        .CLK_IN_FREQ_MHZ(1),
        .POLL_PERIOD_US (PERIOD),
        .DEV_ADDR       (7'h40),
        .REG_PTR        (8'h02),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk_in          (clk_in),
        .n_rst           (n_rst),
        .poll_en_in      (poll_en_in),
        .enable_out      (enable_out),
        .rd_wr_out       (rd_wr_out),
        .continuous_out  (continuous_out),
        .address_out     (address_out),
        .data_bytes_out  (data_bytes_out),
        .wr_data_out     (wr_data_out),
        .ready_in        (ready_in),
        .wr_valid_in     (wr_valid_in),
        .rd_valid_in     (rd_valid_in),
        .rd_data_in      (rd_data_in),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out),
        .error_out       (error_out),
        .err_cnt_out     (err_cnt_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_err;
        logic [15:0] smp;
        logic [7:0]  ecnt;
    } exp_t;
    exp_t exp_q[$];
    int   n_valid = 0;

    task automatic push_exp(input bit e, input logic [15:0] s, input logic [7:0] c);
        exp_t x;
        x.is_err = e;
        x.smp    = s;
        x.ecnt   = c;
        exp_q.push_back(x);
    endtask

    always @(negedge clk_in) begin
        if (n_rst === 1'b1) begin
            if (sample_valid_out === 1'b1 && error_out === 1'b1)
                chk("valid_and_error_together", 1, 0);
            if (sample_valid_out === 1'b1) n_valid++;
            if (sample_valid_out === 1'b1 || error_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_pulse", {31'd0, error_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_kind_is_error", {31'd0, error_out}, {31'd0, e.is_err});
                    chk("sb_sample", {16'd0, sample_out}, {16'd0, e.smp});
                    chk("sb_err_cnt", {24'd0, err_cnt_out}, {24'd0, e.ecnt});
                end
            end
        end
    end

    // ---------------- I2C master model ----------------
    bit          m_wr_ack  = 1'b1;
    int          m_rd_n    = 2;
    int          m_hold    = 0;
    bit          m_stuck   = 1'b0;
    logic [7:0]  m_b0      = 8'hAB;
    logic [7:0]  m_b1      = 8'hCD;
    int          m_wr_cmds = 0;
    int          m_rd_cmds = 0;

    task automatic m_tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin : master
        ready_in = 1'b1; wr_valid_in = 1'b0; rd_valid_in = 1'b0; rd_data_in = 8'h00;
        forever begin
            @(posedge clk_in);
            #1;
            if (enable_out === 1'b1) begin
                if (rd_wr_out === 1'b0) begin
                    m_wr_cmds++;
                    m_tick(1);
                    ready_in = 1'b0;
                    m_tick(2);
                    if (m_wr_ack) begin
                        wr_valid_in = 1'b1; m_tick(1); wr_valid_in = 1'b0;
                    end
                    m_tick(m_hold);
                    while (m_stuck) m_tick(1);
                    ready_in = 1'b1;
                end else begin
                    m_rd_cmds++;
                    m_tick(1);
                    ready_in = 1'b0;
                    m_tick(2);
                    for (int k = 0; k < m_rd_n; k++) begin
                        rd_data_in  = (k == 0) ? m_b0 : m_b1;
                        rd_valid_in = 1'b1; m_tick(1); rd_valid_in = 1'b0; m_tick(1);
                    end
                    m_tick(m_hold);
                    while (m_stuck) m_tick(1);
                    ready_in = 1'b1;
                end
            end
        end
    end

    // ---------------- helpers for the directed sequence ----------------
    task automatic wait_busy(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (busy_out !== lvl && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, {31'd0, busy_out}, {31'd0, lvl});
    endtask

    task automatic wait_rd_req(input int bound, input string tag);
        int n = 0;
        while (!(enable_out === 1'b1 && rd_wr_out === 1'b1) && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, {31'd0, enable_out}, 32'd1);
    endtask

    task automatic wait_en_low(input int bound, input string tag);
        int n = 0;
        while (enable_out !== 1'b0 && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, {31'd0, enable_out}, 32'd0);
    endtask

    task automatic drain(input int bound, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic stop_polling(input string tag);
        poll_en_in = 1'b0;
        wait_busy(1'b0, 2000, tag);
        repeat (2) @(negedge clk_in);
    endtask

    initial begin : global_timeout
        #3_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int          cyc;
        int          v0, r0, w0, bad;
        logic [7:0]  exp_err;
        logic [15:0] cur_sample;

        n_rst = 1'b0;
        poll_en_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);

        // Reset state
        chk("rst_enable",      {31'd0, enable_out},       32'd0);
        chk("rst_rd_wr",       {31'd0, rd_wr_out},        32'd0);
        chk("rst_continuous",  {31'd0, continuous_out},   32'd0);
        chk("rst_address",     {25'd0, address_out},      32'h40);
        chk("rst_data_bytes",  {26'd0, data_bytes_out},   32'd0);
        chk("rst_wr_data",     {24'd0, wr_data_out},      32'd0);
        chk("rst_sample",      {16'd0, sample_out},       32'd0);
        chk("rst_valid",       {31'd0, sample_valid_out}, 32'd0);
        chk("rst_error",       {31'd0, error_out},        32'd0);
        chk("rst_err_cnt",     {24'd0, err_cnt_out},      32'd0);
        chk("rst_busy",        {31'd0, busy_out},         32'd0);

        // Normal poll: ACKs everywhere, bytes AB CD
        exp_err = 8'd0;
        cur_sample = 16'hABCD;
        push_exp(1'b0, 16'hABCD, 8'd0);
        v0 = n_valid;
        n_rst = 1'b1;
        poll_en_in = 1'b1;
        cyc = 0;
        while (busy_out !== 1'b1 && cyc < 200) begin
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
        end
        chk("first_poll_not_before_period", (cyc >= PERIOD) ? 32'd1 : 32'd0, 32'd1);
        chk("first_poll_not_late", (cyc <= PERIOD + 2) ? 32'd1 : 32'd0, 32'd1);
        chk("wrreq_enable",     {31'd0, enable_out},     32'd1);
        chk("wrreq_rd_wr",      {31'd0, rd_wr_out},      32'd0);
        chk("wrreq_data_bytes", {26'd0, data_bytes_out}, 32'd1);
        chk("wrreq_continuous", {31'd0, continuous_out}, 32'd1);
        chk("wrreq_wr_data",    {24'd0, wr_data_out},    32'h02);
        chk("wrreq_address",    {25'd0, address_out},    32'h40);
        wait_rd_req(100, "rdreq_seen");
        chk("rdreq_data_bytes", {26'd0, data_bytes_out}, 32'd2);
        chk("rdreq_continuous", {31'd0, continuous_out}, 32'd1);
        drain(200, "normal_drain");
        stop_polling("normal_idle");
        chk("normal_one_valid_pulse", n_valid - v0, 32'd1);
        chk("normal_sample", {16'd0, sample_out}, 32'hABCD);
        chk("normal_err_cnt", {24'd0, err_cnt_out}, 32'd0);

        // Write NACK: no wr_valid before ready returns
        m_wr_ack = 1'b0;
        exp_err = 8'd1;
        push_exp(1'b1, cur_sample, exp_err);
        r0 = m_rd_cmds;
        poll_en_in = 1'b1;
        drain(200, "nack_drain");
        stop_polling("nack_idle");
        chk("nack_no_read_issued", m_rd_cmds - r0, 32'd0);
        chk("nack_sample_kept", {16'd0, sample_out}, 32'hABCD);
        chk("nack_err_cnt", {24'd0, err_cnt_out}, 32'd1);
        m_wr_ack = 1'b1;

`ifndef POLLER_TIMEOUT_EN
        // Command stability over a long stall, plus a single follow-on poll
        m_b0 = 8'h12;
        m_b1 = 8'h34;
        m_hold = 500;
        cur_sample = 16'h1234;
        push_exp(1'b0, cur_sample, exp_err);
        push_exp(1'b0, cur_sample, exp_err);
        w0 = m_wr_cmds;
        poll_en_in = 1'b1;
        wait_rd_req(1200, "stab_rdreq_seen");
        wait_en_low(10, "stab_enable_low");
        bad = 0;
        repeat (450) begin
            @(negedge clk_in);
            if (rd_wr_out !== 1'b1 || address_out !== 7'h40 ||
                data_bytes_out !== 6'd2 || enable_out !== 1'b0)
                bad++;
        end
        chk("stab_cmd_unstable_cycles", bad, 32'd0);
        cyc = 0;
        while (exp_q.size() > 1 && cyc < 300) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("stab_first_sample", exp_q.size(), 32'd1);
        m_hold = 0;
        wait_busy(1'b0, 5, "stab_back_to_idle");
        wait_busy(1'b1, 5, "stab_followon_starts");
        poll_en_in = 1'b0;
        drain(300, "stab_drain");
        stop_polling("stab_idle");
        repeat (100) @(negedge clk_in);
        chk("stab_exactly_two_polls", m_wr_cmds - w0, 32'd2);
        chk("stab_sample", {16'd0, sample_out}, 32'h1234);
`endif

        // Short reads: one byte only, 256 times -> saturate at 255
        m_rd_n = 1;
        for (int i = 0; i < 256; i++) begin
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            push_exp(1'b1, cur_sample, exp_err);
        end
        poll_en_in = 1'b1;
        drain(256 * 50 + 500, "short_drain");
        stop_polling("short_idle");
        chk("short_err_cnt_saturated", {24'd0, err_cnt_out}, 32'd255);
        chk("short_sample_kept", {16'd0, sample_out}, {16'd0, cur_sample});
        m_rd_n = 2;

        // Reset asserted while waiting on the read
        m_hold = 20;
        v0 = n_valid;
        poll_en_in = 1'b1;
        wait_rd_req(200, "rst_mid_rdreq_seen");
        wait_en_low(10, "rst_mid_enable_low");
        repeat (3) @(negedge clk_in);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_busy",    {31'd0, busy_out},    32'd0);
        chk("rst_mid_enable",  {31'd0, enable_out},  32'd0);
        chk("rst_mid_sample",  {16'd0, sample_out},  32'd0);
        chk("rst_mid_err_cnt", {24'd0, err_cnt_out}, 32'd0);
        chk("rst_mid_rd_wr",   {31'd0, rd_wr_out},   32'd0);
        poll_en_in = 1'b0;
        @(negedge clk_in);
        n_rst = 1'b1;
        repeat (100) @(negedge clk_in);
        chk("rst_mid_stays_idle", {31'd0, busy_out}, 32'd0);
        chk("rst_mid_no_sample", n_valid - v0, 32'd0);
        m_hold = 0;
        cur_sample = 16'h0000;
        exp_err = 8'd0;

`ifdef POLLER_TIMEOUT_EN
        // Watchdog: master never returns ready after the write handshake
        m_stuck = 1'b1;
        exp_err = 8'd1;
        push_exp(1'b1, cur_sample, exp_err);
        poll_en_in = 1'b1;
        wait_busy(1'b1, 100, "wd_poll_started");
        cyc = 0;
        while (ready_in !== 1'b0 && cyc < 10) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("wd_master_busy", {31'd0, ready_in}, 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        cyc = 0;
        while (error_out !== 1'b1 && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("wd_error_after_cycles", cyc, 32'd50);
        chk("wd_enable_low", {31'd0, enable_out}, 32'd0);
        m_stuck = 1'b0;
        poll_en_in = 1'b0;
        drain(100, "wd_drain");
        stop_polling("wd_idle");
        chk("wd_err_cnt", {24'd0, err_cnt_out}, 32'd1);
`endif

        chk("scoreboard_empty_at_end", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
